// File: rtl/riscv_tag_prop_unit_if.sv
// ID/EX/load/debug signal bundle for the tag propagation unit.
// The master drives the ID, load and control inputs; the slave is the unit itself.
interface riscv_tag_prop_unit_if #(
    parameter int ALU_MODE_WIDTH = 2,
    parameter int CNT_WIDTH      = 16
);
    logic                      id_valid_i;
    logic                      id_ready_o;
    logic [ALU_MODE_WIDTH-1:0] alu_operator_i_mode;
    logic                      register_set_i;
    logic                      set_value_i;
    logic [4:0]                rs1_addr_i;
    logic [4:0]                rs2_addr_i;
    logic                      rs2_used_i;
    logic [4:0]                rd_addr_i;
    logic                      rd_we_i;
    logic                      ex_stall_i;
    logic                      flush_i;
    logic                      load_tag_we_i;
    logic [4:0]                load_tag_addr_i;
    logic                      load_tag_i;
    logic                      rs1_tag_o;
    logic                      rs2_tag_o;
    logic                      ex_valid_o;
    logic [4:0]                ex_rd_addr_o;
    logic                      ex_tag_o;
    logic [CNT_WIDTH-1:0]      taint_cnt_o;
    logic                      taint_cnt_clr_i;

    modport master (
        output id_valid_i, alu_operator_i_mode, register_set_i, set_value_i,
               rs1_addr_i, rs2_addr_i, rs2_used_i, rd_addr_i, rd_we_i,
               ex_stall_i, flush_i, load_tag_we_i, load_tag_addr_i, load_tag_i,
               taint_cnt_clr_i,
        input  id_ready_o, rs1_tag_o, rs2_tag_o, ex_valid_o, ex_rd_addr_o,
               ex_tag_o, taint_cnt_o
    );

    modport slave (
        input  id_valid_i, alu_operator_i_mode, register_set_i, set_value_i,
               rs1_addr_i, rs2_addr_i, rs2_used_i, rd_addr_i, rd_we_i,
               ex_stall_i, flush_i, load_tag_we_i, load_tag_addr_i, load_tag_i,
               taint_cnt_clr_i,
        output id_ready_o, rs1_tag_o, rs2_tag_o, ex_valid_o, ex_rd_addr_o,
               ex_tag_o, taint_cnt_o
    );
endinterface

// File: rtl/riscv_tag_prop_unit.sv
// EX-side register tag propagation: 32x1 tag file, ID/EX capture, EX tag
// computation and commit, in-flight forwarding and a saturating taint counter.
module riscv_tag_prop_unit #(
    parameter int ALU_MODE_WIDTH = 2,
    parameter int CNT_WIDTH      = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    riscv_tag_prop_unit_if.slave  bus
);

    localparam logic [ALU_MODE_WIDTH-1:0] ALU_MODE_OLD   = ALU_MODE_WIDTH'(2'b00);
    localparam logic [ALU_MODE_WIDTH-1:0] ALU_MODE_AND   = ALU_MODE_WIDTH'(2'b01);
    localparam logic [ALU_MODE_WIDTH-1:0] ALU_MODE_OR    = ALU_MODE_WIDTH'(2'b10);

    logic [31:0]               r_tag_file;

    logic                      r_ex_valid;
    logic [ALU_MODE_WIDTH-1:0] r_ex_mode;
    logic                      r_ex_reg_set;
    logic                      r_ex_set_value;
    logic                      r_ex_t1;
    logic                      r_ex_t2;
    logic                      r_ex_t_old;
    logic [4:0]                r_ex_rd;
    logic                      r_ex_we;

    logic                      r_out_valid;
    logic [4:0]                r_out_rd;
    logic                      r_out_tag;
    logic [CNT_WIDTH-1:0]      r_taint_cnt;

    logic                      w_capture;
    logic                      w_commit;
    logic                      w_ex_write;
    logic                      w_ex_pending;
    logic                      w_load_write;
    logic                      w_ex_tag;
    logic                      w_rs1_tag;
    logic                      w_rs2_tag;
    logic                      w_rd_tag;
    logic                      w_t2;

    // Priority: in-flight EX result, then WB load write, then the file.
    function automatic logic fwd_read(
        input logic [4:0]  addr,
        input logic [31:0] file,
        input logic        ex_pending,
        input logic [4:0]  ex_rd,
        input logic        ex_tag,
        input logic        ld_we,
        input logic [4:0]  ld_addr,
        input logic        ld_tag
    );
        if (addr == 5'd0)                   return 1'b0;
        if (ex_pending && ex_rd == addr)    return ex_tag;
        if (ld_we && ld_addr == addr)       return ld_tag;
        return file[addr];
    endfunction

    assign w_capture    = bus.id_valid_i && !bus.ex_stall_i;
    assign w_commit     = r_ex_valid && !bus.ex_stall_i && !bus.flush_i;
    assign w_ex_write   = w_commit && r_ex_we && (r_ex_rd != 5'd0);
    assign w_ex_pending = r_ex_valid && r_ex_we && (r_ex_rd != 5'd0);
    // The newer EX instruction wins a same-index collision with the load port.
    assign w_load_write = bus.load_tag_we_i && (bus.load_tag_addr_i != 5'd0) &&
                          !(w_ex_write && (r_ex_rd == bus.load_tag_addr_i));

    assign w_rs1_tag = fwd_read(bus.rs1_addr_i, r_tag_file, w_ex_pending, r_ex_rd, w_ex_tag,
                                bus.load_tag_we_i, bus.load_tag_addr_i, bus.load_tag_i);
    assign w_rs2_tag = fwd_read(bus.rs2_addr_i, r_tag_file, w_ex_pending, r_ex_rd, w_ex_tag,
                                bus.load_tag_we_i, bus.load_tag_addr_i, bus.load_tag_i);
    assign w_rd_tag  = fwd_read(bus.rd_addr_i, r_tag_file, w_ex_pending, r_ex_rd, w_ex_tag,
                                bus.load_tag_we_i, bus.load_tag_addr_i, bus.load_tag_i);
    assign w_t2      = bus.rs2_used_i ? w_rs2_tag : w_rs1_tag;

    always_comb begin
        // NOTE: assign a default before any branch so no path leaves the signal unassigned (no latch).
        w_ex_tag = 1'b0;
        if (r_ex_reg_set) begin
            w_ex_tag = r_ex_set_value;
        end else begin
            case (r_ex_mode)
                ALU_MODE_OLD: w_ex_tag = r_ex_t_old;
                ALU_MODE_AND: w_ex_tag = r_ex_t1 & r_ex_t2;
                ALU_MODE_OR:  w_ex_tag = r_ex_t1 | r_ex_t2;
                default:      w_ex_tag = 1'b0;
            endcase
        end
    end

    // NOTE: the tag file is only 32 flops and must read all-zero after reset, so it is reset like any register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_file <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            if (w_load_write) r_tag_file[bus.load_tag_addr_i] <= bus.load_tag_i;
            if (w_ex_write)   r_tag_file[r_ex_rd]             <= w_ex_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid     <= 1'b0;
            r_ex_mode      <= '0;
            r_ex_reg_set   <= 1'b0;
            r_ex_set_value <= 1'b0;
            r_ex_t1        <= 1'b0;
            r_ex_t2        <= 1'b0;
            r_ex_t_old     <= 1'b0;
            r_ex_rd        <= 5'd0;
            r_ex_we        <= 1'b0;
        end else if (bus.flush_i) begin
            r_ex_valid <= 1'b0;
        end else if (!bus.ex_stall_i) begin
            r_ex_valid <= bus.id_valid_i;
            if (w_capture) begin
                r_ex_mode      <= bus.alu_operator_i_mode;
                r_ex_reg_set   <= bus.register_set_i;
                r_ex_set_value <= bus.set_value_i;
                r_ex_t1        <= w_rs1_tag;
                r_ex_t2        <= w_t2;
                r_ex_t_old     <= w_rd_tag;
                r_ex_rd        <= bus.rd_addr_i;
                r_ex_we        <= bus.rd_we_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_rd    <= 5'd0;
            r_out_tag   <= 1'b0;
            r_taint_cnt <= '0;
        end else begin
            r_out_valid <= w_commit;
            if (w_commit) begin
                r_out_rd  <= r_ex_rd;
                r_out_tag <= w_ex_tag;
            end
            if (bus.taint_cnt_clr_i) begin
                r_taint_cnt <= '0;
            end else if (w_ex_write && w_ex_tag && !(&r_taint_cnt)) begin
                r_taint_cnt <= r_taint_cnt + 1'b1;
            end
        end
    end

    assign bus.id_ready_o   = !bus.ex_stall_i;
    assign bus.rs1_tag_o    = w_rs1_tag;
    assign bus.rs2_tag_o    = w_rs2_tag;
    assign bus.ex_valid_o   = r_out_valid;
    assign bus.ex_rd_addr_o = r_out_rd;
    assign bus.ex_tag_o     = r_out_tag;
    assign bus.taint_cnt_o  = r_taint_cnt;

endmodule

// File: doc/riscv_tag_prop_unit.md
Name: riscv_tag_prop_unit

Overview:
EX-side consumer of the ID-stage mode decoder's per-instruction propagation mode and register-set flag.
- Owns the 32x1-bit register tag file and captures mode plus source tags into an ID/EX register.
- Computes the destination tag in EX and commits it to the tag file at end of EX.
- Forwards in-flight tags to the next ID read and counts tainted commits for debug visibility.

Parameters:
ALU_MODE_WIDTH, 2, width of propagation mode field; encodings from riscv_defines: ALU_MODE_OLD=2'b00, ALU_MODE_AND=2'b01, ALU_MODE_OR=2'b10, ALU_MODE_CLEAR=2'b11
CNT_WIDTH, 16, width of tainted-commit counter

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
id_valid_i  in  1  ID holds a decoded instruction
id_ready_o  out  1  unit accepts ID instruction this cycle
alu_operator_i_mode  in  ALU_MODE_WIDTH  propagation mode from mode decoder
register_set_i  in  1  explicit tag-set instruction (funct7 1111010)
set_value_i  in  1  tag written when register_set_i=1
rs1_addr_i  in  5  source 1 index
rs2_addr_i  in  5  source 2 index
rs2_used_i  in  1  instruction reads rs2 (0 for immediate forms)
rd_addr_i  in  5  destination index
rd_we_i  in  1  instruction writes rd
ex_stall_i  in  1  EX stage stalled
flush_i  in  1  kill instruction in EX (branch/exception)
load_tag_we_i  in  1  WB-stage load tag write
load_tag_addr_i  in  5  load destination index
load_tag_i  in  1  tag of loaded word
rs1_tag_o  out  1  forwarded rs1 tag in ID (combinational, for checks)
rs2_tag_o  out  1  forwarded rs2 tag in ID (combinational)
ex_valid_o  out  1  EX tag committed this cycle
ex_rd_addr_o  out  5  committed destination index
ex_tag_o  out  1  committed destination tag
taint_cnt_o  out  CNT_WIDTH  saturating count of commits with tag=1
taint_cnt_clr_i  in  1  synchronous clear of taint_cnt_o

Behaviour:
- Reset (async, rst_n=0):
  - all 32 tags = 0
  - EX register invalid
  - ex_valid_o=0, ex_rd_addr_o=0, ex_tag_o=0, taint_cnt_o=0
- Entry 0 always reads 0; writes to index 0 are discarded and are not counted.
- ID read per source, combinational, priority:
  - (a) pending EX commit (EX valid, we=1, rd==addr, rd!=0)
  - (b) load port (load_tag_we_i, addr match, addr!=0)
  - (c) tag file
- The same forwarding applies to the ID read of rd's current tag (needed for OLD mode).
- id_ready_o = !ex_stall_i.
- Capture into EX on id_valid_i && id_ready_o: mode, register_set, set_value, t1, t2, t_old, rd, we.
  - t2 := t1 when rs2_used_i=0.
- EX valid next-cycle rules:
  - flush_i=1 -> 0. Flush overrides capture and stall.
  - else ex_stall_i=1 -> hold all EX state.
  - else -> id_valid_i.
- EX result tag:
  - register_set=1 -> set_value (overrides mode)
  - OLD -> t_old
  - AND -> t1&t2
  - OR -> t1|t2
  - CLEAR -> 0
- Commit when EX valid && !ex_stall_i && !flush_i:
  - ex_valid_o=1 that cycle, registered one cycle after capture (latency 1 when unstalled).
  - Tag file written at the clock edge if we=1 and rd!=0.
  - we=0 still pulses ex_valid_o, with no file write.
- Simultaneous EX commit and load write to the same index: EX value wins (EX instruction is newer). Different indices: both written.
- ex_rd_addr_o/ex_tag_o update only on commit and hold otherwise.
- taint_cnt_o:
  - +1 per file-write commit with tag=1, saturating at all-ones.
  - Clear has priority over increment in the same cycle.

Test Plan:
- Reset sequence -> all read tags 0, taint_cnt_o=0, ex_valid_o=0; then load write x5 tag=1, read rs1=5 next cycle -> rs1_tag_o=1.
- x1=1, x2=0; OR rd=3 rs1=1 rs2=2 -> ex_tag_o=1 at cycle+1, x3=1, taint_cnt_o=1. Repeat with AND rd=4 -> x4=0, count unchanged.
- Back-to-back dependency: OR x3<-x1|x2 then AND rd=6 rs1=3 rs2=1 -> second sees forwarded x3=1, x6=1, no bubble.
- ex_stall_i held 3 cycles with EX valid -> id_ready_o=0, no commit, EX held; release -> single commit.
- flush_i while EX holds CLEAR rd=1 (x1=1) -> no commit, x1 stays 1. Same cycle with load write x7=1 and EX commit x7 tag=0 -> x7=0.
- register_set_i=1, set_value_i=1, rd=0 -> x0 reads 0, count unchanged. Force counter to 16'hFFFF plus tainted commit -> stays 16'hFFFF; clr and increment together -> 0.
